// File: rtl/network_arbiter_mc.sv
// network_arbiter_mc: per-channel trust flags written through an addressed
// state port, plus a round-robin arbiter for the shared network port. Each
// grant is held for a bounded time and is withdrawn from any channel that
// becomes untrusted.

module network_arbiter_mc #(
  parameter int                N_CHAN          = 4,
  parameter int                DATA_W          = 32,
  parameter logic [DATA_W-1:0] UNTRUSTED_VALUE = DATA_W'(32'h0000_0002),
  parameter int                HOLD_MAX        = 16,
  localparam int               CW              = $clog2(N_CHAN)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_chan,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [N_CHAN-1:0] req,
  output logic [N_CHAN-1:0] trusted,
  output logic [N_CHAN-1:0] grant,
  output logic              grant_valid,
  output logic              wr_err
);

  localparam int HW = $clog2(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_r;
  logic [CW-1:0]     owner_r;
  logic [CW-1:0]     rr_ptr_r;
  logic [HW-1:0]     hold_cnt_r;
  logic [N_CHAN-1:0] trusted_r;
  logic [N_CHAN-1:0] grant_r;
  logic              grant_valid_r;
  logic              wr_err_r;

  logic [0:0]        state_n_s;
  logic [CW-1:0]     owner_n_s;
  logic [CW-1:0]     rr_ptr_n_s;
  logic [HW-1:0]     hold_n_s;
  logic [N_CHAN-1:0] grant_n_s;
  logic [N_CHAN-1:0] elig_s;
  logic              wr_in_range_s;
  logic [CW:0]       pick_idle_s;
  logic [CW:0]       pick_next_s;

  // Returns {found, index} of the first set mask bit at or after start, wrapping.
  function automatic logic [CW:0] rr_pick(input logic [N_CHAN-1:0] mask,
                                          input logic [CW-1:0]     start);
    logic          found;
    logic [CW-1:0] idx;
    int            pos;
    found = 1'b0;
    idx   = {CW{1'b0}};
    for (int i = 0; i < N_CHAN; i++) begin
      pos = (int'(start) + i) % N_CHAN;
      if (!found && mask[pos]) begin
        found = 1'b1;
        idx   = CW'(pos);
      end
    end
    return {found, idx};
  endfunction

  // Channel index following c, wrapping modulo N_CHAN.
  function automatic logic [CW-1:0] next_chan(input logic [CW-1:0] c);
    return CW'((int'(c) + 1) % N_CHAN);
  endfunction

  // One-hot vector with bit c set.
  function automatic logic [N_CHAN-1:0] onehot(input logic [CW-1:0] c);
    return {{(N_CHAN-1){1'b0}}, 1'b1} << c;
  endfunction

  // Eligibility uses the registered trust flags, so a same-cycle write cannot
  // influence this cycle's arbitration.
  assign elig_s        = req & trusted_r;
  assign wr_in_range_s = ({1'b0, wr_chan} < (CW+1)'(N_CHAN));

  // Arbitration FSM next-state: idle pick, owner drop, hold-limit rotation.
  always_comb begin
    state_n_s   = state_r;
    owner_n_s   = owner_r;
    rr_ptr_n_s  = rr_ptr_r;
    hold_n_s    = hold_cnt_r;
    grant_n_s   = grant_r;
    pick_idle_s = rr_pick(elig_s, rr_ptr_r);
    pick_next_s = rr_pick(elig_s & ~onehot(owner_r), next_chan(owner_r));
    case (state_r)
      ST_IDLE: begin
        if (pick_idle_s[CW]) begin
          grant_n_s = onehot(pick_idle_s[CW-1:0]);
          owner_n_s = pick_idle_s[CW-1:0];
          hold_n_s  = {HW{1'b0}};
          state_n_s = ST_BUSY;
        end else begin
          grant_n_s = {N_CHAN{1'b0}};
        end
      end
      ST_BUSY: begin
        if (!elig_s[owner_r]) begin
          // Owner dropped its request or lost trust: always pass through IDLE.
          grant_n_s  = {N_CHAN{1'b0}};
          rr_ptr_n_s = next_chan(owner_r);
          state_n_s  = ST_IDLE;
        end else if ((hold_cnt_r == HOLD_LAST) && pick_next_s[CW]) begin
          // Hold budget spent and someone is waiting: hand over directly.
          grant_n_s  = onehot(pick_next_s[CW-1:0]);
          owner_n_s  = pick_next_s[CW-1:0];
          hold_n_s   = {HW{1'b0}};
          rr_ptr_n_s = next_chan(owner_r);
        end else begin
          grant_n_s = onehot(owner_r);
          if (hold_cnt_r != HOLD_LAST) begin
            hold_n_s = hold_cnt_r + HW'(1);
          end else begin
            hold_n_s = hold_cnt_r;
          end
        end
      end
      default: begin
        grant_n_s = {N_CHAN{1'b0}};
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // Arbitration state and registered grant outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      owner_r       <= {CW{1'b0}};
      rr_ptr_r      <= {CW{1'b0}};
      hold_cnt_r    <= {HW{1'b0}};
      grant_r       <= {N_CHAN{1'b0}};
      grant_valid_r <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      owner_r       <= owner_n_s;
      rr_ptr_r      <= rr_ptr_n_s;
      hold_cnt_r    <= hold_n_s;
      grant_r       <= grant_n_s;
      grant_valid_r <= |grant_n_s;
    end
  end

  // Trust flags: full-width compare against the untrusted marker on write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      trusted_r <= {N_CHAN{1'b1}};
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (wr_en && (wr_chan == CW'(i))) begin
          trusted_r[i] <= (wr_data != UNTRUSTED_VALUE);
        end
      end
    end
  end

  // One-cycle error pulse for writes addressed past the last channel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= wr_en & ~wr_in_range_s;
    end
  end

  assign trusted     = trusted_r;
  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign wr_err      = wr_err_r;

  network_arbiter_mc_chk #(.N_CHAN(N_CHAN)) u_chk (
    .clk     (clk),
    .resetn  (resetn),
    .trusted (trusted_r),
    .grant   (grant_r)
  );

endmodule

// Invariant checker: grant is one-hot or zero and only ever lands on a channel
// that was trusted in the preceding cycle.
module network_arbiter_mc_chk #(
  parameter int N_CHAN = 4
) (
  input logic              clk,
  input logic              resetn,
  input logic [N_CHAN-1:0] trusted,
  input logic [N_CHAN-1:0] grant
);

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!resetn)
    $onehot0(grant));

  a_grant_trusted: assert property (@(posedge clk) disable iff (!resetn)
    ((grant & ~$past(trusted)) == {N_CHAN{1'b0}}));

endmodule

// File: tb/tb_network_arbiter_mc.sv
// Directed testbench for network_arbiter_mc. A second instance with six
// channels exercises out-of-range writes, which a 4-channel index cannot reach.

module tb_network_arbiter_mc;

  logic        clk;
  logic        resetn;
  logic        wr_en;
  logic [1:0]  wr_chan;
  logic [31:0] wr_data;
  logic [3:0]  req;
  logic [3:0]  trusted;
  logic [3:0]  grant;
  logic        grant_valid;
  logic        wr_err;

  logic        wr_en6;
  logic [2:0]  wr_chan6;
  logic [31:0] wr_data6;
  logic [5:0]  req6;
  logic [5:0]  trusted6;
  logic [5:0]  grant6;
  logic        grant_valid6;
  logic        wr_err6;

  int checks;
  int failures;

  network_arbiter_mc dut (
    .clk         (clk),
    .resetn      (resetn),
    .wr_en       (wr_en),
    .wr_chan     (wr_chan),
    .wr_data     (wr_data),
    .req         (req),
    .trusted     (trusted),
    .grant       (grant),
    .grant_valid (grant_valid),
    .wr_err      (wr_err)
  );

  network_arbiter_mc #(.N_CHAN(6)) dut6 (
    .clk         (clk),
    .resetn      (resetn),
    .wr_en       (wr_en6),
    .wr_chan     (wr_chan6),
    .wr_data     (wr_data6),
    .req         (req6),
    .trusted     (trusted6),
    .grant       (grant6),
    .grant_valid (grant_valid6),
    .wr_err      (wr_err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    wr_en = 1'b0; wr_chan = 2'd0; wr_data = 32'd0; req = 4'b0000;
    wr_en6 = 1'b0; wr_chan6 = 3'd0; wr_data6 = 32'd0; req6 = 6'b000000;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (trusted !== 4'b1111) begin failures++; $display("FAIL reset_trusted got=%b exp=1111", trusted); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset_grant_valid got=%b exp=0", grant_valid); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
    checks++; if (trusted6 !== 6'b111111) begin failures++; $display("FAIL reset_trusted6 got=%b exp=111111", trusted6); end
  endtask

  task automatic test_trust_write();
    do_reset();
    wr_en = 1'b1; wr_chan = 2'd2; wr_data = 32'h0000_0002;
    step();
    checks++; if (trusted !== 4'b1011) begin failures++; $display("FAIL untrust_ch2 got=%b exp=1011", trusted); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL valid_write_err got=%b exp=0", wr_err); end
    wr_data = 32'h0000_0000;
    step();
    checks++; if (trusted !== 4'b1111) begin failures++; $display("FAIL retrust_ch2 got=%b exp=1111", trusted); end
    step();
    checks++; if (trusted !== 4'b1111) begin failures++; $display("FAIL rewrite_same got=%b exp=1111", trusted); end
    // Upper bits differ from the marker, so the channel stays trusted.
    wr_chan = 2'd1; wr_data = 32'h8000_0002;
    step();
    checks++; if (trusted !== 4'b1111) begin failures++; $display("FAIL full_width_cmp got=%b exp=1111", trusted); end
    wr_chan = 2'd3; wr_data = 32'h0000_0002;
    step();
    checks++; if (trusted !== 4'b0111) begin failures++; $display("FAIL untrust_ch3 got=%b exp=0111", trusted); end
    wr_en = 1'b0;
    step();
    checks++; if (trusted !== 4'b0111) begin failures++; $display("FAIL hold_no_write got=%b exp=0111", trusted); end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 4'b1010;
    step();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL first_grant got=%b exp=0010", grant); end
    checks++; if (grant_valid !== 1'b1) begin failures++; $display("FAIL first_grant_valid got=%b exp=1", grant_valid); end
    for (int k = 1; k < 16; k++) begin
      step();
      checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL hold_ch1 cyc=%0d got=%b exp=0010", k, grant); end
    end
    step();
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL rotate_to_ch3 got=%b exp=1000", grant); end
    for (int k = 1; k < 16; k++) begin
      step();
      checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL hold_ch3 cyc=%0d got=%b exp=1000", k, grant); end
    end
    step();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rotate_to_ch1 got=%b exp=0010", grant); end
    req = 4'b0000;
    step();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL release_grant got=%b exp=0000", grant); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%b exp=0", grant_valid); end
  endtask

  task automatic test_untrust_owner();
    do_reset();
    req = 4'b1010;
    step();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL owner_grant got=%b exp=0010", grant); end
    wr_en = 1'b1; wr_chan = 2'd1; wr_data = 32'h0000_0002;
    step();
    wr_en = 1'b0;
    checks++; if (trusted !== 4'b1101) begin failures++; $display("FAIL owner_untrusted got=%b exp=1101", trusted); end
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL owner_grant_T got=%b exp=0010", grant); end
    step();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL owner_revoked got=%b exp=0000", grant); end
    step();
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL regrant_ch3 got=%b exp=1000", grant); end
    req = 4'b0000;
  endtask

  task automatic test_wr_err();
    do_reset();
    wr_en6 = 1'b1; wr_chan6 = 3'd6; wr_data6 = 32'h0000_0002;
    step();
    wr_en6 = 1'b0;
    checks++; if (wr_err6 !== 1'b1) begin failures++; $display("FAIL oor_err_pulse got=%b exp=1", wr_err6); end
    checks++; if (trusted6 !== 6'b111111) begin failures++; $display("FAIL oor_trusted got=%b exp=111111", trusted6); end
    step();
    checks++; if (wr_err6 !== 1'b0) begin failures++; $display("FAIL oor_err_clear got=%b exp=0", wr_err6); end
    wr_en6 = 1'b1; wr_chan6 = 3'd5;
    step();
    wr_en6 = 1'b0;
    checks++; if (trusted6 !== 6'b011111) begin failures++; $display("FAIL last_chan_write got=%b exp=011111", trusted6); end
    checks++; if (wr_err6 !== 1'b0) begin failures++; $display("FAIL last_chan_err got=%b exp=0", wr_err6); end
    wr_en6 = 1'b1; wr_chan6 = 3'd7; wr_data6 = 32'h0000_0000;
    step();
    wr_en6 = 1'b0;
    checks++; if (wr_err6 !== 1'b1) begin failures++; $display("FAIL oor7_err got=%b exp=1", wr_err6); end
    checks++; if (trusted6 !== 6'b011111) begin failures++; $display("FAIL oor7_trusted got=%b exp=011111", trusted6); end
  endtask

  task automatic test_blocked_untrusted();
    do_reset();
    wr_en = 1'b1; wr_chan = 2'd0; wr_data = 32'h0000_0002;
    step();
    wr_en = 1'b0;
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL blocked cyc=%0d got=%b exp=0000", k, grant); end
    end
    wr_en = 1'b1; wr_data = 32'h0000_0007;
    step();
    wr_en = 1'b0;
    checks++; if (trusted !== 4'b1111) begin failures++; $display("FAIL unblock_trusted got=%b exp=1111", trusted); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL unblock_early got=%b exp=0000", grant); end
    step();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL unblock_grant got=%b exp=0001", grant); end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    wr_en = 1'b1; wr_chan = 2'd0; wr_data = 32'h0000_0002;
    step();
    wr_chan = 2'd3; req = 4'b0100;
    step();
    wr_en = 1'b0;
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL pre_reset_grant got=%b exp=0100", grant); end
    checks++; if (trusted !== 4'b0110) begin failures++; $display("FAIL pre_reset_trusted got=%b exp=0110", trusted); end
    // A write presented on the reset edge must be ignored.
    resetn = 1'b0; wr_en = 1'b1; wr_chan = 2'd1; wr_data = 32'h0000_0002;
    step();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL mid_reset_grant got=%b exp=0000", grant); end
    checks++; if (trusted !== 4'b1111) begin failures++; $display("FAIL mid_reset_trusted got=%b exp=1111", trusted); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL mid_reset_wr_err got=%b exp=0", wr_err); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", grant_valid); end
    resetn = 1'b1; wr_en = 1'b0; req = 4'b0000;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    wr_en = 1'b0; wr_chan = 2'd0; wr_data = 32'd0; req = 4'b0000;
    wr_en6 = 1'b0; wr_chan6 = 3'd0; wr_data6 = 32'd0; req6 = 6'b000000;
    test_reset();
    test_trust_write();
    test_rotation();
    test_untrust_owner();
    test_wr_err();
    test_blocked_untrusted();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
